// File: rtl/byte_link_pkg.sv
// Shared types and widths for the byte serial link.
// Holds the byte width, counter width and FSM state enum.
package byte_link_pkg;

  localparam int BYTE_W       = 8;
  localparam int BYTES_SENT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_t;

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous FIFO, DEPTH a power of two.
// Ports: push/din, pop/dout (show-ahead), clr, full, empty, level.
module byte_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clr,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int LW = $clog2(DEPTH);
  localparam logic [LW:0]   LVL_ONE = (LW+1)'(1);
  localparam logic [LW-1:0] PTR_ONE = LW'(1);
  localparam logic [LW:0]   LVL_MAX = (LW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [LW-1:0]    wr_ptr;
  logic [LW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_MAX);
  assign empty   = (level == '0);
  assign do_push = push && !full && !clr;
  assign do_pop  = pop && !empty && !clr;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      unique case ({do_push, do_pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/byte_serializer.sv
// Buffers parallel bytes and shifts them out MSB first with an idle gap.
// Ports: in_data/in_valid/in_ready, abort, serial_out, shift_enable, busy, fifo_level, bytes_sent.
module byte_serializer
  import byte_link_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [BYTE_W-1:0]         in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      abort,
  output logic                      serial_out,
  output logic                      shift_enable,
  output logic                      busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [BYTES_SENT_W-1:0]   bytes_sent
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_t              state, state_n;
  logic [BYTE_W-2:0]   shreg, shreg_n;
  logic [2:0]          bit_cnt, bit_cnt_n;
  logic [GW-1:0]       gap_cnt, gap_cnt_n;
  logic                se_q, se_n;
  logic                so_q, so_n;
  logic [BYTES_SENT_W-1:0] sent_q, sent_n;

  logic                push;
  logic                pop;
  logic                load;
  logic                full;
  logic                empty;
  logic [BYTE_W-1:0]   head;

  // Registered-state only: in_valid never feeds back into in_ready.
  assign in_ready = rst_n && !full && !abort;
  assign push     = in_valid && in_ready;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BYTE_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .clr   (abort),
    .din   (in_data),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bit_cnt_n = bit_cnt;
    gap_cnt_n = gap_cnt;
    se_n      = se_q;
    so_n      = so_q;
    sent_n    = sent_q;
    load      = 1'b0;
    pop       = 1'b0;
    if (abort) begin
      state_n = IDLE;
      se_n    = 1'b0;
      so_n    = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          load = !empty;
        end
        SHIFT: begin
          if (bit_cnt != 3'd0) begin
            so_n      = shreg[BYTE_W-2];
            shreg_n   = {shreg[BYTE_W-3:0], 1'b0};
            bit_cnt_n = bit_cnt - 3'd1;
          end else begin
            se_n      = 1'b0;
            so_n      = 1'b0;
            sent_n    = sent_q + BYTES_SENT_W'(1);
            gap_cnt_n = GW'(GAP_CYCLES - 1);
            state_n   = GAP;
          end
        end
        GAP: begin
          if (gap_cnt != '0) begin
            gap_cnt_n = gap_cnt - GW'(1);
          end else if (!empty) begin
            load = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
      // The head's MSB goes out directly; the rest waits in shreg.
      if (load) begin
        pop       = 1'b1;
        shreg_n   = head[BYTE_W-2:0];
        bit_cnt_n = 3'd7;
        se_n      = 1'b1;
        so_n      = head[BYTE_W-1];
        state_n   = SHIFT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      se_q    <= 1'b0;
      so_q    <= 1'b0;
      sent_q  <= '0;
    end else begin
      state   <= state_n;
      shreg   <= shreg_n;
      bit_cnt <= bit_cnt_n;
      gap_cnt <= gap_cnt_n;
      se_q    <= se_n;
      so_q    <= so_n;
      sent_q  <= sent_n;
    end
  end

  assign serial_out   = so_q;
  assign shift_enable = se_q;
  assign bytes_sent   = sent_q;
  assign busy         = (state != IDLE) || !empty;

endmodule

// File: tb/tb_byte_serializer.sv
// Randomised bench for byte_serializer.
// A byte-level queue model rebuilds each byte from the serial stream.
module tb_byte_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        abort;
  logic        serial_out;
  logic        shift_enable;
  logic        busy;
  logic [2:0]  fifo_level;
  logic [15:0] bytes_sent;

  int total = 0;
  int bad   = 0;

  byte_serializer #(
    .FIFO_DEPTH (4),
    .GAP_CYCLES (1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .abort        (abort),
    .serial_out   (serial_out),
    .shift_enable (shift_enable),
    .busy         (busy),
    .fifo_level   (fifo_level),
    .bytes_sent   (bytes_sent)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input int unsigned got,
                       input int unsigned exp_v);
    total++;
    if (got !== exp_v) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp_v);
    end
  endtask

  // Reference model: bytes accepted but not yet fully seen downstream.
  logic [7:0]  exp_q [$];
  logic [15:0] sent_cnt = '0;
  logic [7:0]  cur      = '0;
  int          nbits    = 0;
  bit          trunc_ok = 1'b0;
  int          max_lvl  = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      sent_cnt = '0;
      nbits    = 0;
      trunc_ok = 1'b0;
    end else begin
      check("rdy_rule", in_ready,
            (fifo_level < 3'd4) && !abort);
      check("lvl_rng", fifo_level <= 3'd4, 1);
      if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
      if (shift_enable) begin
        check("run_len", nbits < 8, 1);
        cur   = {cur[6:0], serial_out};
        nbits = nbits + 1;
      end else begin
        check("so_idle", serial_out, 0);
        if (nbits == 8) begin
          check("q_nonempty", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            check("byte", cur, exp_q.pop_front());
          end
          sent_cnt = sent_cnt + 16'd1;
          check("sent", bytes_sent, sent_cnt);
        end else if (nbits != 0 && !trunc_ok) begin
          check("short_run", nbits, 8);
        end
        nbits    = 0;
        trunc_ok = 1'b0;
      end
      if (abort) begin
        exp_q.delete();
        trunc_ok = 1'b1;
      end
      if (in_valid && in_ready) exp_q.push_back(in_data);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    @(posedge clk);
    #1;
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) check("push_tmo", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || nbits != 0) && n < 3000) begin
      n++;
      @(negedge clk);
    end
    check("idle_tmo", n < 3000, 1);
    check("q_drained", exp_q.size(), 0);
    check("sent_tot", bytes_sent, sent_cnt);
  endtask

  logic [7:0] pat;
  logic       se_log [17];
  logic       so_log [17];
  logic [15:0] bs;

  initial begin
    rst_n    = 1'b0;
    in_data  = '0;
    in_valid = 1'b0;
    abort    = 1'b0;

    repeat (3) @(negedge clk);
    in_valid = 1'b1;
    #1;
    check("rst_se", shift_enable, 0);
    check("rst_so", serial_out, 0);
    check("rst_busy", busy, 0);
    check("rst_lvl", fifo_level, 0);
    check("rst_sent", bytes_sent, 0);
    check("rst_rdy", in_ready, 0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_rdy", in_ready, 1);
    check("rel_lvl", fifo_level, 0);

    // Single byte with exact latency and bit order.
    pat = 8'hA5;
    send_byte(pat);
    @(negedge clk);
    check("lat_se", shift_enable, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("one_se", shift_enable, 1);
      check("one_bit", serial_out, pat[7-i]);
    end
    @(negedge clk);
    check("one_se_lo", shift_enable, 0);
    check("one_sent", bytes_sent, 1);
    check("one_busy_gap", busy, 1);
    @(negedge clk);
    check("one_busy_lo", busy, 0);

    // Back-to-back pair: exactly one low cycle between bytes.
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    @(posedge clk);
    #1;
    in_data  = 8'h3C;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      se_log[i] = shift_enable;
      so_log[i] = serial_out;
    end
    pat = 8'h3C;
    check("b2b_first", se_log[0], 1);
    check("b2b_last", se_log[7], 1);
    check("b2b_gap", se_log[8], 0);
    for (int i = 0; i < 8; i++) begin
      check("b2b_se2", se_log[9+i], 1);
      check("b2b_bit2", so_log[9+i], pat[7-i]);
    end
    wait_idle();
    check("b2b_sent", bytes_sent, 3);

    // Saturate the FIFO while the shifter is busy.
    max_lvl = 0;
    for (int i = 0; i < 10; i++) send_byte(8'($urandom));
    check("full_lvl", max_lvl, 4);
    wait_idle();

    // Abort mid-byte with two bytes queued.
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    @(posedge clk);
    #1;
    in_data  = 8'h11;
    @(posedge clk);
    #1;
    in_data  = 8'h22;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("ab_pre_lvl", fifo_level, 2);
    check("ab_pre_se", shift_enable, 1);
    bs    = bytes_sent;
    abort = 1'b1;
    #1;
    check("ab_rdy", in_ready, 0);
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    check("ab_se", shift_enable, 0);
    check("ab_so", serial_out, 0);
    check("ab_lvl", fifo_level, 0);
    check("ab_sent", bytes_sent, bs);
    check("ab_busy", busy, 0);
    send_byte(8'h5A);
    wait_idle();

    // Random traffic with random idle spacing.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 12)) @(posedge clk);
      end
      send_byte(8'($urandom));
    end
    wait_idle();
    check("busy_end", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
